// File: rtl/fir_interp_mc.sv
// Multichannel polyphase FIR interpolator: one input sample yields L outputs (phases 0..L-1).
// Optional macro FIR_INTERP_MC_SAT_EN saturates results; otherwise results wrap to SAMPLE_SIZE bits.
module fir_interp_mc #(
  parameter int CH          = 2,
  parameter int L_MAX       = 8,
  parameter int N           = 16,
  parameter int SAMPLE_SIZE = 16,
  parameter int COEFF_SIZE  = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [$clog2(L_MAX+1)-1:0]             l_sel,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [SAMPLE_SIZE-1:0]                 din,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [SAMPLE_SIZE-1:0]                 dout,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] out_ch,
  output logic [$clog2(L_MAX)-1:0]               out_phase,
  input  logic                                   c_we,
  input  logic [$clog2(L_MAX*N)-1:0]             c_addr,
  input  logic [COEFF_SIZE-1:0]                  c_in,
  output logic                                   c_ready
);

  localparam int LW   = $clog2(L_MAX + 1);
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW   = $clog2(L_MAX);
  localparam int AW   = $clog2(L_MAX * N);
  localparam int NW   = (N > 1) ? $clog2(N) : 1;
  localparam int DAW  = (CH * N > 1) ? $clog2(CH * N) : 1;
  localparam int MW   = $clog2(N + 1);
  localparam int ACCW = SAMPLE_SIZE + COEFF_SIZE + $clog2(N);
  localparam int EW   = ACCW + LW + 1;
  localparam logic signed [EW-1:0] RND = EW'(1) <<< (COEFF_SIZE - 2);

  typedef enum logic [2:0] {CLR, IDLE, WR, MAC, OUT} state_t;

  state_t state_reg, state_next;

  logic [DAW-1:0]                      clr_cnt_reg;
  logic [CHW-1:0]                      ch_cnt_reg, ch_lat_reg;
  logic [SAMPLE_SIZE-1:0]              din_lat_reg;
  logic [LW-1:0]                       l_lat_reg;
  logic [PW-1:0]                       p_reg;
  logic [MW-1:0]                       mac_cnt_reg;
  logic signed [ACCW-1:0]              acc_reg;
  logic [NW-1:0]                       wp_reg [CH];
  logic [SAMPLE_SIZE-1:0]              dout_reg;
  logic [CHW-1:0]                      out_ch_reg;
  logic [PW-1:0]                       out_phase_reg;

  logic [SAMPLE_SIZE-1:0]              dl_mem [CH*N];
  logic [COEFF_SIZE-1:0]               coef_mem [L_MAX*N];
  logic [SAMPLE_SIZE-1:0]              dl_rdata;
  logic [COEFF_SIZE-1:0]               coef_rdata;

  logic                                accept, last_phase, mac_done, dl_we;
  logic [NW-1:0]                       wp_cur, wp_inc;
  logic [MW-1:0]                       k_rd;
  logic [NW:0]                         tap_sum, tap_idx;
  logic [DAW-1:0]                      dl_raddr, dl_waddr;
  logic [SAMPLE_SIZE-1:0]              dl_wdata;
  logic [AW-1:0]                       c_raddr;
  logic [LW-1:0]                       l_clamped;
  logic signed [SAMPLE_SIZE+COEFF_SIZE-1:0] prod;
  logic signed [ACCW-1:0]              acc_sum;
  logic signed [EW-1:0]                acc_ext, l_ext, scaled, rounded;
  logic [SAMPLE_SIZE-1:0]              res;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= CLR;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CLR:     if (clr_cnt_reg == DAW'(CH * N - 1)) state_next = IDLE;
      IDLE:    if (accept) state_next = WR;
      WR:      state_next = MAC;
      MAC:     if (mac_done) state_next = OUT;
      OUT:     if (out_ready) state_next = last_phase ? IDLE : MAC;
      default: state_next = CLR;
    endcase
  end

  // Handshake outputs
  always_comb begin
    c_ready   = (state_reg == IDLE);
    in_ready  = (state_reg == IDLE) && !c_we;
    out_valid = (state_reg == OUT);
  end

  assign accept     = in_valid && in_ready;
  assign mac_done   = (mac_cnt_reg == MW'(N));
  assign last_phase = (int'(p_reg) + 1 >= int'(l_lat_reg));
  assign l_clamped  = (l_sel == '0) ? LW'(1) : ((l_sel > LW'(L_MAX)) ? LW'(L_MAX) : l_sel);

  // Tap k of phase p pairs sample x[n-k] (newest first) with coefficient p*N+k.
  always_comb begin
    wp_cur   = wp_reg[ch_lat_reg];
    wp_inc   = (wp_cur == NW'(N - 1)) ? '0 : wp_cur + NW'(1);
    k_rd     = (mac_cnt_reg < MW'(N)) ? mac_cnt_reg : '0;
    tap_sum  = {1'b0, wp_cur} + (NW+1)'(N - 1) - (NW+1)'(k_rd);
    tap_idx  = (tap_sum >= (NW+1)'(N)) ? tap_sum - (NW+1)'(N) : tap_sum;
    dl_raddr = DAW'(int'(ch_lat_reg) * N + int'(tap_idx));
    c_raddr  = AW'(int'(p_reg) * N + int'(k_rd));
    dl_we    = (state_reg == CLR) || (state_reg == WR);
    dl_waddr = (state_reg == CLR) ? clr_cnt_reg : DAW'(int'(ch_lat_reg) * N + int'(wp_cur));
    dl_wdata = (state_reg == CLR) ? '0 : din_lat_reg;
  end

  always_ff @(posedge clk) begin
    if (dl_we) dl_mem[dl_waddr] <= dl_wdata;
    dl_rdata <= dl_mem[dl_raddr];
  end

  // Coefficients are not reset so they survive rst.
  always_ff @(posedge clk) begin
    if (c_we && c_ready) coef_mem[c_addr] <= c_in;
    coef_rdata <= coef_mem[c_raddr];
  end

  always_comb begin
    prod    = $signed(dl_rdata) * $signed(coef_rdata);
    acc_sum = acc_reg + ACCW'(prod);
    acc_ext = EW'(acc_sum);
    l_ext   = EW'($signed({1'b0, l_lat_reg}));
    scaled  = acc_ext * l_ext;
    rounded = scaled + RND;
  end

`ifdef FIR_INTERP_MC_SAT_EN
  localparam logic signed [EW-1:0] SMAX = (EW'(1) <<< (SAMPLE_SIZE - 1)) - EW'(1);
  localparam logic signed [EW-1:0] SMIN = -SMAX - EW'(1);
  logic signed [EW-1:0] shifted;
  always_comb begin
    shifted = rounded >>> (COEFF_SIZE - 1);
    if (shifted > SMAX)      res = SAMPLE_SIZE'(SMAX);
    else if (shifted < SMIN) res = SAMPLE_SIZE'(SMIN);
    else                     res = SAMPLE_SIZE'(shifted);
  end
`else
  always_comb res = SAMPLE_SIZE'(rounded >>> (COEFF_SIZE - 1));
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_wp
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                               wp_reg[gi] <= '0;
        else if (state_reg == WR && ch_lat_reg == CHW'(gi))    wp_reg[gi] <= wp_inc;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt_reg   <= '0;
      ch_cnt_reg    <= '0;
      ch_lat_reg    <= '0;
      din_lat_reg   <= '0;
      l_lat_reg     <= LW'(1);
      p_reg         <= '0;
      mac_cnt_reg   <= '0;
      acc_reg       <= '0;
      dout_reg      <= '0;
      out_ch_reg    <= '0;
      out_phase_reg <= '0;
    end else begin
      case (state_reg)
        CLR: clr_cnt_reg <= clr_cnt_reg + DAW'(1);
        IDLE: begin
          if (accept) begin
            din_lat_reg <= din;
            l_lat_reg   <= l_clamped;
            ch_lat_reg  <= ch_cnt_reg;
            ch_cnt_reg  <= (ch_cnt_reg == CHW'(CH - 1)) ? '0 : ch_cnt_reg + CHW'(1);
            p_reg       <= '0;
          end
        end
        WR: mac_cnt_reg <= '0;
        MAC: begin
          // First MAC cycle only primes the RAM read pipeline.
          acc_reg     <= (mac_cnt_reg == '0) ? '0 : acc_sum;
          mac_cnt_reg <= mac_cnt_reg + MW'(1);
          if (mac_done) begin
            dout_reg      <= res;
            out_ch_reg    <= ch_lat_reg;
            out_phase_reg <= p_reg;
          end
        end
        OUT: begin
          if (out_ready) begin
            mac_cnt_reg <= '0;
            if (!last_phase) p_reg <= p_reg + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign dout      = dout_reg;
  assign out_ch    = out_ch_reg;
  assign out_phase = out_phase_reg;

endmodule

// File: tb/tb_fir_interp_mc.sv
// Directed bench for fir_interp_mc: a reference model fills a scoreboard queue at each accepted input,
// and each DUT output is popped and compared.
module tb_fir_interp_mc;

  localparam int CH = 2, L_MAX = 8, N = 16, S = 16, C = 16;
  localparam int LW = $clog2(L_MAX + 1);
  localparam int AW = $clog2(L_MAX * N);

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] l_sel;
  logic          in_valid, in_ready;
  logic [S-1:0]  din;
  logic          out_valid, out_ready;
  logic [S-1:0]  dout;
  logic [0:0]    out_ch;
  logic [2:0]    out_phase;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [C-1:0]  c_in;
  logic          c_ready;

  fir_interp_mc #(.CH(CH), .L_MAX(L_MAX), .N(N), .SAMPLE_SIZE(S), .COEFF_SIZE(C)) dut (
    .clk(clk), .rst(rst), .l_sel(l_sel),
    .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .out_ch(out_ch), .out_phase(out_phase),
    .c_we(c_we), .c_addr(c_addr), .c_in(c_in), .c_ready(c_ready)
  );

  always #5 clk = ~clk;

  typedef struct {logic [S-1:0] d; int ch; int ph;} exp_t;
  exp_t q[$];

  logic signed [C-1:0] coef_m [L_MAX*N];
  longint              hist [CH][N];
  int                  ch_m;
  int                  checks = 0;
  int                  failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [S-1:0] model(input int ch, input int ph, input int l);
    longint acc, r;
    acc = 0;
    for (int k = 0; k < N; k++) acc += longint'(coef_m[ph*N+k]) * hist[ch][k];
    r = (acc * l + (longint'(1) << (C - 2))) >>> (C - 1);
`ifdef FIR_INTERP_MC_SAT_EN
    if (r > (longint'(1) << (S - 1)) - 1) r = (longint'(1) << (S - 1)) - 1;
    else if (r < -(longint'(1) << (S - 1))) r = -(longint'(1) << (S - 1));
`endif
    return S'(r);
  endfunction

  task automatic do_reset();
    int z;
    bit quiet;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; c_we = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("reset_outputs", {out_valid, in_ready, c_ready, dout, out_ch, out_phase}, 0);
    rst = 1'b0;
    q.delete();
    ch_m = 0;
    for (int c = 0; c < CH; c++) for (int k = 0; k < N; k++) hist[c][k] = 0;
    z = 0; quiet = 1'b1;
    while (!in_ready && z < 1000) begin
      if ({out_valid, c_ready, dout, out_ch, out_phase} !== 0) quiet = 1'b0;
      @(negedge clk);
      z++;
    end
    check("clr_outputs_zero", quiet, 1);
    check("clr_cycles", z, CH * N);
    check("c_ready_idle", c_ready, 1);
    $display("reset done: clr_cycles=%0d", z);
  endtask

  // mode 0: 0x4000 on tap 0 only, 1: all 0x7FFF, 2: random small values
  task automatic load_coefs(input int mode);
    int v;
    for (int a = 0; a < L_MAX * N; a++) begin
      @(negedge clk);
      if (mode == 0)      v = (a % N == 0) ? 32'h4000 : 0;
      else if (mode == 1) v = 32'h7FFF;
      else                v = int'($urandom_range(0, 8191)) - 4096;
      c_we = 1'b1; c_addr = AW'(a); c_in = C'(v);
      coef_m[a] = C'(v);
      if (a == 0) begin
        #1;
        check("c_ready_load", c_ready, 1);
        check("in_ready_blocked_by_c_we", in_ready, 0);
      end
    end
    @(negedge clk);
    c_we = 1'b0;
    $display("coefficients loaded mode=%0d", mode);
  endtask

  task automatic run_input(input logic [S-1:0] d, input int l, input bit stall);
    int lc, ch, cnt, first, to;
    bit stalled, stable;
    logic [S-1:0] hd;
    logic [0:0] hc;
    logic [2:0] hp;
    exp_t e;
    lc = (l == 0) ? 1 : ((l > L_MAX) ? L_MAX : l);
    @(negedge clk);
    in_valid = 1'b1; din = d; l_sel = LW'(l); out_ready = !stall;
    to = 0;
    while (!in_ready && to < 500) begin @(negedge clk); to++; end
    check("accept_ready", in_ready, 1);
    ch = ch_m;
    ch_m = (ch_m + 1) % CH;
    for (int k = N - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
    hist[ch][0] = longint'($signed(d));
    for (int p = 0; p < lc; p++) q.push_back('{model(ch, p, lc), ch, p});
    @(negedge clk);
    in_valid = 1'b0; l_sel = LW'(l + 3); din = ~d;
    cnt = 1; first = 0; stalled = 1'b0;
    while (cnt < 2000) begin
      if (cnt == 2) begin c_we = 1'b1; c_addr = '0; c_in = 16'h5A5A; end
      if (cnt == 5) c_we = 1'b0;
      if (out_valid) begin
        if (first == 0) first = cnt;
        if (stall && !stalled) begin
          hd = dout; hc = out_ch; hp = out_phase; stable = 1'b1;
          repeat (20) begin
            @(negedge clk);
            cnt++;
            if (!out_valid || dout !== hd || out_ch !== hc || out_phase !== hp || in_ready !== 1'b0)
              stable = 1'b0;
          end
          check("stall_stable", stable, 1);
          out_ready = 1'b1;
          stalled = 1'b1;
        end
        check("out_expected_pending", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          $display("out ch=%0d phase=%0d dout=%h expect=%h", out_ch, out_phase, dout, e.d);
          check("dout", dout, e.d);
          check("out_ch", out_ch, e.ch);
          check("out_phase", out_phase, e.ph);
        end
      end
      if (in_ready) break;
      @(negedge clk);
      cnt++;
    end
    check("idle_return", in_ready, 1);
    check("first_latency", first, N + 3);
    if (!stall) check("input_interval", cnt, lc * (N + 2) + 2);
    check("outputs_missing", q.size(), 0);
    out_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int to;
    rst = 1'b1; in_valid = 1'b0; din = '0; l_sel = LW'(4); out_ready = 1'b1;
    c_we = 1'b0; c_addr = '0; c_in = '0;
    do_reset();

    load_coefs(0);
    run_input(16'h4000, 4, 1'b0);
    run_input(16'h2000, 4, 1'b0);
    run_input(16'h0000, 4, 1'b0);
    run_input(16'hC000, 2, 1'b0);
    run_input(16'h4000, 0, 1'b0);
    run_input(16'h1234, 15, 1'b0);
    run_input(16'h4000, 4, 1'b1);

    load_coefs(1);
    for (int i = 0; i < 16; i++) run_input(16'h7000, 4, 1'b0);

    load_coefs(2);
    for (int i = 0; i < 8; i++)
      run_input(S'($urandom_range(0, 65535)), int'($urandom_range(0, 9)), 1'b0);

    // Abort a computation in MAC with reset; nothing may come out of it.
    @(negedge clk);
    in_valid = 1'b1; din = 16'h3000; l_sel = LW'(4);
    to = 0;
    while (!in_ready && to < 500) begin @(negedge clk); to++; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_mac_no_valid", out_valid, 0);
    do_reset();
    for (int i = 0; i < 4; i++)
      run_input(S'($urandom_range(0, 65535)), int'($urandom_range(1, 8)), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
